accum_instr_issuer: RTL
=======================

# accum_instr_issuer

Issuing side of the accumulate instruction interface. Accepts one accumulation job at a time (candidate count, capacity) and a stream of embedding elements. Drives the 64-bit instruction/data pair into the accumulate engine as the sequence CONFIG, ACCUMULATE×n, DISABLE. Reports the per-job sum, the dropped-element count and any backpressure seen from the engine.

## Interface
- DATA_W, 64, width of vec_data, data_out, result_in, job_sum
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- job_valid  in  1  job descriptor valid
- job_ready  out  1  issuer can accept a job (high only in IDLE)
- job_count  in  28  sum candidates in this job
- job_capacity  in  32  capacity programmed into the engine
- vec_valid  in  1  element valid
- vec_ready  out  1  element accepted when valid&ready
- vec_data  in  DATA_W  element value
- instruction  out  64  to engine; [63:60] opcode, 0 = NOP
- data_out  out  DATA_W  to engine data input
- result_in  in  DATA_W  engine running accumulate result
- bp_signal  in  1  engine backpressure, registered one cycle after the instruction it answers
- done  out  1  one-cycle pulse, job_sum/dropped/err_bp valid
- job_sum  out  DATA_W  result_in(end) − result_in(start), mod 2^DATA_W
- dropped  out  28  elements consumed but not issued
- err_bp  out  1  engine asserted bp_signal for an issued ACCUMULATE during the job
- busy  out  1  state ≠ IDLE

## Operation
- Opcodes: NOP=0, CONFIG=1, ACCUMULATE=2, DISABLE=3.
- CONFIG word: {4'h1, job_count, job_capacity}. ACCUMULATE and DISABLE words: opcode with the low 60 bits zero.
- On job handshake:
  - latch count C and capacity K;
  - n_issue = min(C, K), compared as zero-extended 32-bit values;
  - n_drop = C − n_issue.
- The engine never clears its result on CONFIG. The issuer captures base = result_in during the CFG cycle, so job_sum = final − base with wrap-around.
- FSM states:
  - IDLE: job_ready=1, instruction=NOP. On handshake → CFG.
  - CFG: CONFIG is on the bus. Capture base. → DIS if C=0, else ACCUM.
  - ACCUM: vec_ready=1. Each handshake decrements remaining (starts at C).
    - While issued < n_issue, the next-cycle instruction is ACCUMULATE and data_out=vec_data.
    - Otherwise the next-cycle instruction is NOP and dropped increments.
    - A handshake that takes remaining to 0 → DIS.
    - No handshake → next-cycle instruction is NOP and data_out holds its value.
  - DIS: next-cycle instruction=DISABLE. → WAIT.
  - WAIT: next-cycle instruction=NOP. Register job_sum, dropped, err_bp and done=1. → IDLE.
- err_bp monitoring:
  - acc_vis flag = the visible instruction is ACCUMULATE, registered.
  - err_bp sets on acc_vis & bp_signal. It is sticky for the job and cleared at job accept.
  - bp_signal is ignored after NOP, CONFIG or DISABLE.
- K=0 with C>0: every element is dropped. No ACCUMULATE is issued, job_sum=0, dropped=C.
- Elements presented in IDLE, CFG, DIS or WAIT are not accepted (vec_ready=0).

## Timing
- All outputs are registered.
- Reset values: job_ready=0 during reset and 1 from the first cycle after release. vec_ready, done, err_bp, busy, dropped, job_sum, data_out = 0. instruction=NOP.
- Job handshake at cycle t:
  - CONFIG visible at t+1;
  - first ACCUMULATE visible at t+3 at the earliest (element handshake at t+2).
- Element handshake at cycle u → instruction/data visible at u+1. The engine sums at the end of u+1; result_in reflects it at u+2.
- Last element handshake at u:
  - u+1: DIS state; the last ACCUMULATE is visible.
  - u+2: WAIT state; DISABLE is visible; result_in and bp_signal are final.
  - u+3: done=1, job_ready=1.
- C=N with back-to-back elements: done at t+N+4.
- The done cycle may coincide with a new job handshake. The new job's clear of err_bp/dropped takes effect the following cycle.
- reset_n asserted mid-job: immediate return to IDLE and NOP on instruction. The partial job is discarded and no done pulse is produced. Engine reset is owned externally.

## Structure
- Shared package accum_pkg:
  - opcode constants;
  - INSTR_W=64;
  - field widths CNT_W=28 and CAP_W=32;
  - state enum {IDLE, CFG, ACCUM, DIS, WAIT};
  - instruction-word builder functions.
- The engine side imports the same package.
- No sub-module. The single FSM with datapath registers forms the whole block.

## Test plan
- Reset release, then job C=3, K=10, elements 5, 7, 9 back-to-back with an engine model (result starts at 0):
  - bus sequence CONFIG {1,3,10}, ACC×3, DISABLE;
  - done at t+7 with job_sum=21, dropped=0, err_bp=0.
- Second job C=2, K=10 on an engine holding 21, elements 100 and 1 → job_sum=101 (not 122).
- C=5, K=2, elements 1..5:
  - exactly two ACCUMULATE words, carrying 1 and 2;
  - job_sum=3, dropped=3; all five elements handshaken.
- C=0 → CONFIG, DISABLE, done with job_sum=0, dropped=0. vec_ready never asserts.
- Engine model forced to assert bp_signal after the second ACCUMULATE of a C=4, K=4 job → err_bp=1 at done. The next clean job reports err_bp=0.
- reset_n pulsed low in the second ACCUM cycle of a C=4 job:
  - instruction goes to NOP asynchronously, no done pulse;
  - job_ready=1 after release; a fresh job completes normally.
- Gaps in vec_valid (pattern 1,0,0,1) → NOP on instruction during the gaps; job_sum is correct.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared definitions for the accumulate instruction interface (issuer and engine side).
// Opcodes, field widths, FSM state encoding and instruction-word builders.
package accum_pkg;

  localparam int INSTR_W = 64;
  localparam int OP_W    = 4;
  localparam int CNT_W   = 28;
  localparam int CAP_W   = 32;

  localparam logic [OP_W-1:0] OP_NOP     = 4'h0;
  localparam logic [OP_W-1:0] OP_CONFIG  = 4'h1;
  localparam logic [OP_W-1:0] OP_ACCUM   = 4'h2;
  localparam logic [OP_W-1:0] OP_DISABLE = 4'h3;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    ACCUM,
    DIS,
    WAIT
  } state_t;

  function automatic logic [INSTR_W-1:0] instr_op(input logic [OP_W-1:0] op);
    return {op, {(INSTR_W-OP_W){1'b0}}};
  endfunction

  function automatic logic [INSTR_W-1:0] instr_config(input logic [CNT_W-1:0] cnt,
                                                      input logic [CAP_W-1:0] cap);
    return {OP_CONFIG, cnt, cap};
  endfunction

  function automatic logic [OP_W-1:0] instr_opcode(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1 -: OP_W];
  endfunction

endpackage

// File: rtl/accum_instr_issuer.sv
// Issues CONFIG, ACCUMULATE x n, DISABLE to the accumulate engine for one job at a time.
// All outputs registered; element handshake appears on the bus one cycle later, done 3 cycles after the last element.
module accum_instr_issuer
  import accum_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [CNT_W-1:0]   job_count,
  input  logic [CAP_W-1:0]   job_capacity,
  input  logic               vec_valid,
  output logic               vec_ready,
  input  logic [DATA_W-1:0]  vec_data,
  output logic [INSTR_W-1:0] instruction,
  output logic [DATA_W-1:0]  data_out,
  input  logic [DATA_W-1:0]  result_in,
  input  logic               bp_signal,
  output logic               done,
  output logic [DATA_W-1:0]  job_sum,
  output logic [CNT_W-1:0]   dropped,
  output logic               err_bp,
  output logic               busy
);

  state_t            state;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  issued;
  logic [CNT_W-1:0]  n_issue;
  logic [CNT_W-1:0]  drop_cnt;
  logic [DATA_W-1:0] base;
  logic              err_seen;
  logic              acc_vis;

  logic              job_hs;
  logic              vec_hs;
  logic [CNT_W-1:0]  job_n_issue;
  logic              can_issue;
  logic              last_elem;
  logic              bp_hit;

  assign job_hs    = job_valid & job_ready;
  assign vec_hs    = vec_valid & vec_ready;
  assign can_issue = issued < n_issue;
  assign last_elem = remaining == CNT_W'(1);
  assign bp_hit    = acc_vis & bp_signal;

  // Capacity is a full 32-bit value: a large capacity must never truncate the count.
  assign job_n_issue = ({{(CAP_W-CNT_W){1'b0}}, job_count} < job_capacity)
                       ? job_count : job_capacity[CNT_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      job_ready   <= 1'b0;
      vec_ready   <= 1'b0;
      instruction <= instr_op(OP_NOP);
      data_out    <= '0;
      done        <= 1'b0;
      job_sum     <= '0;
      dropped     <= '0;
      err_bp      <= 1'b0;
      busy        <= 1'b0;
      remaining   <= '0;
      issued      <= '0;
      n_issue     <= '0;
      drop_cnt    <= '0;
      base        <= '0;
      err_seen    <= 1'b0;
      acc_vis     <= 1'b0;
    end else begin
      done        <= 1'b0;
      instruction <= instr_op(OP_NOP);
      // bp_signal answers the previous visible word; only ACCUMULATE answers count.
      acc_vis     <= (instr_opcode(instruction) == OP_ACCUM);
      if (bp_hit) err_seen <= 1'b1;

      case (state)
        IDLE: begin
          if (job_hs) begin
            state       <= CFG;
            job_ready   <= 1'b0;
            busy        <= 1'b1;
            instruction <= instr_config(job_count, job_capacity);
            remaining   <= job_count;
            n_issue     <= job_n_issue;
            issued      <= '0;
            drop_cnt    <= '0;
            err_seen    <= 1'b0;
            dropped     <= '0;
            err_bp      <= 1'b0;
          end else begin
            job_ready <= 1'b1;
          end
        end

        CFG: begin
          // Engine keeps its result across jobs, so the sum is taken relative to this point.
          base <= result_in;
          if (remaining == '0) begin
            state <= DIS;
          end else begin
            state     <= ACCUM;
            vec_ready <= 1'b1;
          end
        end

        ACCUM: begin
          if (vec_hs) begin
            remaining <= remaining - CNT_W'(1);
            if (can_issue) begin
              instruction <= instr_op(OP_ACCUM);
              data_out    <= vec_data;
              issued      <= issued + CNT_W'(1);
            end else begin
              drop_cnt <= drop_cnt + CNT_W'(1);
            end
            if (last_elem) begin
              state     <= DIS;
              vec_ready <= 1'b0;
            end
          end
        end

        DIS: begin
          instruction <= instr_op(OP_DISABLE);
          state       <= WAIT;
        end

        WAIT: begin
          job_sum   <= result_in - base;
          dropped   <= drop_cnt;
          err_bp    <= err_seen | bp_hit;
          done      <= 1'b1;
          state     <= IDLE;
          job_ready <= 1'b1;
          busy      <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          vec_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
